// File: rtl/hdsiso_seq.sv
// ---------------------------------------------------------------------------
// hdsiso_seq
//
// Turns the bit-serial HDSISO storage chain (DEPTH flops, shared shift enable)
// into a byte-wide delay line with valid/ready handshakes on both sides.
//
// An accepted byte is shifted into stage 0 LSB first over 8 cycles. The 8 bits
// leaving the last stage on those same edges are reassembled into a byte.
// Once the chain holds NBYTES valid bytes, that byte is presented on out_data.
// Until then it is discarded, because it is either reset zeros or stale data
// from before a flush.
//
// Ports
//   CLK        clock, rising edge
//   RESET_B    asynchronous active-low reset (shared with the chain flops)
//   in_data    byte to store
//   in_valid   in_data is valid
//   in_ready   byte accepted this cycle when in_valid is also high (registered)
//   out_data   byte that left the chain (registered)
//   out_valid  out_data is valid
//   out_ready  consumer takes out_data
//   flush      one-cycle request to mark the chain empty (IDLE only)
//   sr_shift   shift enable to the chain (registered)
//   sr_din     serial bit into chain stage 0 (registered)
//   sr_dout    serial bit from chain stage DEPTH-1
//   level      number of valid bytes in the chain, 0..NBYTES
//   busy       high while shifting or holding an output byte
// ---------------------------------------------------------------------------
module hdsiso_seq #(
    parameter int DEPTH = 64,
    parameter int LVL_W = 8
) (
    input  logic             CLK,
    input  logic             RESET_B,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic             sr_shift,
    output logic             sr_din,
    input  logic             sr_dout,
    output logic [LVL_W-1:0] level,
    output logic             busy
);

    localparam int               NBYTES   = DEPTH / 8;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(NBYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [2:0]       bit_cnt_q,   bit_cnt_d;
    logic [LVL_W-1:0] level_q,     level_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q,  out_data_d;
    logic             sr_shift_q,  sr_shift_d;
    logic             sr_din_q,    sr_din_d;

    // Data-only registers: their contents are meaningless outside SHIFT, so
    // they carry no reset.
    logic [7:0]       din_byte_q;
    logic [6:0]       cap_q;
    logic             load_byte;
    logic             capture_bit;

    // Saturating increment: level stops at NBYTES and never wraps.
    function automatic logic [LVL_W-1:0] level_inc(input logic [LVL_W-1:0] lvl);
        if (lvl >= LVL_FULL) begin
            return LVL_FULL;
        end
        return lvl + LVL_W'(1);
    endfunction

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        level_d     = level_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sr_shift_d  = sr_shift_q;
        sr_din_d    = sr_din_q;
        load_byte   = 1'b0;
        capture_bit = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (flush) begin
                    // Chain contents are left alone; restarting the count is
                    // enough to make the stale bits be discarded later.
                    level_d = '0;
                end else if (in_valid && in_ready_q) begin
                    load_byte  = 1'b1;
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = 3'd0;
                    sr_shift_d = 1'b1;
                    sr_din_d   = in_data[0];
                    in_ready_d = 1'b0;
                end
            end

            ST_SHIFT: begin
                // The chain shifts on this edge too, so sr_dout is still the
                // old last-stage bit, i.e. bit bit_cnt_q of the leaving byte.
                if (bit_cnt_q == 3'd7) begin
                    bit_cnt_d  = 3'd0;
                    sr_shift_d = 1'b0;
                    sr_din_d   = 1'b0;
                    if (level_q < LVL_FULL) begin
                        level_d    = level_inc(level_q);
                        state_d    = ST_IDLE;
                        in_ready_d = 1'b1;
                    end else begin
                        // Bit 7 goes straight from the chain into out_data.
                        out_data_d  = {sr_dout, cap_q};
                        out_valid_d = 1'b1;
                        state_d     = ST_HOLD;
                    end
                end else begin
                    capture_bit = 1'b1;
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    sr_din_d    = din_byte_q[bit_cnt_d];
                end
            end

            ST_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
                sr_shift_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Control and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            level_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            sr_shift_q  <= 1'b0;
            sr_din_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            level_q     <= level_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sr_shift_q  <= sr_shift_d;
            sr_din_q    <= sr_din_d;
        end
    end

    // -----------------------------------------------------------------------
    // Data registers: outgoing byte and incoming reassembly
    // -----------------------------------------------------------------------
    // cap_q fills from the top, so after seven captures bit 0 of the leaving
    // byte sits in cap_q[0] and bit 6 in cap_q[6].
    always_ff @(posedge CLK) begin
        if (load_byte) begin
            din_byte_q <= in_data;
        end
        if (capture_bit) begin
            cap_q <= {sr_dout, cap_q[6:1]};
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sr_shift  = sr_shift_q;
    assign sr_din    = sr_din_q;
    assign level     = level_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hdsiso_seq.sv
// ---------------------------------------------------------------------------
// tb_hdsiso_seq
//
// Bench for hdsiso_seq with a 16-bit chain (two bytes). The chain is a
// shift register with async reset and enable. The reference model treats the
// chain as a FIFO of NB bytes plus a fill counter.
// ---------------------------------------------------------------------------
module tb_hdsiso_seq;

    localparam int DEPTH = 16;
    localparam int LVL_W = 8;
    localparam int NB    = DEPTH / 8;

    logic             CLK;
    logic             RESET_B;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             flush;
    logic             sr_shift;
    logic             sr_din;
    logic             sr_dout;
    logic [LVL_W-1:0] level;
    logic             busy;

    hdsiso_seq #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) dut (
        .CLK       (CLK),
        .RESET_B   (RESET_B),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .sr_shift  (sr_shift),
        .sr_din    (sr_din),
        .sr_dout   (sr_dout),
        .level     (level),
        .busy      (busy)
    );

    // Storage chain: DEPTH reset flops with a shared shift enable.
    logic [DEPTH-1:0] chain;
    always_ff @(posedge CLK or negedge RESET_B) begin
        if (!RESET_B) begin
            chain <= '0;
        end else if (sr_shift) begin
            chain <= {chain[DEPTH-2:0], sr_din};
        end
    end
    assign sr_dout = chain[DEPTH-1];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 400000", $time);
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: chain as a byte FIFO (oldest first) plus fill count.
    logic [7:0] m_q[$];
    int         m_level;
    longint     acc_time;

    task automatic model_reset();
        m_q = {};
        for (int i = 0; i < NB; i++) m_q.push_back(8'h00);
        m_level = 0;
    endtask

    // Push one byte; entered and left on a falling edge with the DUT idle.
    task automatic push(input logic [7:0] b, input int stall, input bit noise);
        int         n;
        int         nshift;
        bit         exp_out;
        logic [7:0] exp_b;
        in_data  = b;
        in_valid = 1'b1;
        flush    = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) begin
            check("accept_timeout", n, 0);
            in_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        acc_time = $time;
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);

        exp_out = (m_level == NB);
        exp_b   = m_q.pop_front();
        m_q.push_back(b);
        if (!exp_out) m_level++;

        nshift = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (sr_shift === 1'b1) nshift++;
            if (noise) begin
                in_valid  = 1'($urandom);
                flush     = 1'($urandom);
                out_ready = 1'($urandom);
            end
        end
        @(negedge CLK);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        check("shift_cycles", nshift, 8);
        check("shift_done", sr_shift, 1'b0);
        check("level", level, m_level);
        check("out_valid", out_valid, exp_out);
        if (exp_out) begin
            check("out_data", out_data, exp_b);
            check("in_ready_hold", in_ready, 1'b0);
            check("busy_hold", busy, 1'b1);
            for (int s = 0; s < stall; s++) begin
                if (noise) begin
                    in_valid = 1'($urandom);
                    flush    = 1'($urandom);
                end
                @(negedge CLK);
                check("bp_data", out_data, exp_b);
                check("bp_valid", out_valid, 1'b1);
                check("bp_in_ready", in_ready, 1'b0);
                check("bp_shift", sr_shift, 1'b0);
            end
            in_valid  = 1'b0;
            flush     = 1'b0;
            out_ready = 1'b1;
            @(posedge CLK);
            #1;
            out_ready = 1'b0;
            @(negedge CLK);
            check("out_clear", out_valid, 1'b0);
            check("level_hold", level, m_level);
        end
        check("in_ready_ret", in_ready, 1'b1);
        check("busy_idle", busy, 1'b0);
    endtask

    // Flush from IDLE, optionally with a competing in_valid.
    task automatic do_flush(input bit with_valid);
        flush    = 1'b1;
        in_valid = with_valid;
        in_data  = 8'($urandom);
        @(negedge CLK);
        flush    = 1'b0;
        in_valid = 1'b0;
        m_level  = 0;
        check("flush_level", level, 0);
        check("flush_no_accept", sr_shift, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, in_ready, 1'b1);
        check({tag, "_level"}, level, 0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_data"}, out_data, 8'h00);
        check({tag, "_sr_shift"}, sr_shift, 1'b0);
        check({tag, "_sr_din"}, sr_din, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_chain"}, chain, 0);
    endtask

    initial begin
        longint t_first;
        RESET_B   = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        model_reset();

        // Reset
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET_B = 1'b1;
        @(negedge CLK);
        check_reset_state("reset");

        // Fill: no output, level 1 then 2, nine cycles between accepts
        push(8'hA5, 0, 1'b0);
        t_first = acc_time;
        push(8'h3C, 0, 1'b0);
        check("accept_gap", 32'((acc_time - t_first) / 10), 9);

        // Delay line with the chain full
        push(8'h81, 0, 1'b0);
        push(8'hFF, 0, 1'b0);
        push(8'h00, 0, 1'b0);

        // Back-pressure: 20 cycles with out_ready low
        push(8'h42, 20, 1'b0);

        // Flush with competing in_valid while full
        do_flush(1'b1);
        push(8'h11, 0, 1'b0);
        push(8'h22, 0, 1'b0);
        push(8'h33, 0, 1'b0);

        // Randomized traffic with ignored-input noise
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_flush(1'($urandom));
            end else begin
                push(8'($urandom), int'($urandom_range(0, 3)), 1'b1);
            end
        end

        // Reset in the middle of a shift
        @(negedge CLK);
        in_data  = 8'hC3;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge CLK);
        #2;
        RESET_B = 1'b0;
        #1;
        check_reset_state("midreset");
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RESET_B = 1'b1;
        @(negedge CLK);
        check("post_reset_ready", in_ready, 1'b1);
        push(8'h5A, 0, 1'b0);
        push(8'h6B, 0, 1'b0);
        push(8'h7C, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
